// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, arbiter state encoding and datapath width
package alu_pkg;

  localparam int ALU_DATAPATH_WIDTH = 64;
  localparam int ALU_CTRL_WIDTH     = 4;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first requester at or after ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;
  logic             found;

  // Wrap is explicit so non-power-of-two NUM_REQ never visits a phantom slot.
  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer time-sharing one ALU among NUM_CORES cores
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATAPATH_WIDTH = ALU_DATAPATH_WIDTH,
  parameter int NUM_CORES      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CORES-1:0]                  req_in,
  input  logic [NUM_CORES*DATAPATH_WIDTH-1:0]   a_in,
  input  logic [NUM_CORES*DATAPATH_WIDTH-1:0]   b_in,
  input  logic [NUM_CORES*ALU_CTRL_WIDTH-1:0]   ctrl_in,
  output logic [NUM_CORES-1:0]                  ack_out,
  output logic [NUM_CORES-1:0]                  done_out,
  output logic [DATAPATH_WIDTH-1:0]             result_out,
  output logic                                  zero_out,
  output logic                                  busy_out,
  output logic [DATAPATH_WIDTH-1:0]             alu_a_out,
  output logic [DATAPATH_WIDTH-1:0]             alu_b_out,
  output logic [ALU_CTRL_WIDTH-1:0]             alu_ctrl_out,
  input  logic [DATAPATH_WIDTH-1:0]             alu_accum_in,
  input  logic                                  alu_zero_in
);

  localparam int PTR_W = $clog2(NUM_CORES);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          win_q;
  logic [NUM_CORES-1:0]      win_grant_q;
  logic [NUM_CORES-1:0]      pick_grant;
  logic [PTR_W-1:0]          pick_idx;
  logic [DATAPATH_WIDTH-1:0] sel_a, sel_b;
  logic [ALU_CTRL_WIDTH-1:0] sel_ctrl;
  logic [PTR_W-1:0]          rr_next;

  rr_pick #(
    .NUM_REQ (NUM_CORES),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (req_in),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Operand mux keyed on the one-hot grant so every slice index is a constant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_grant[i]) begin
        sel_a    = a_in[i*DATAPATH_WIDTH +: DATAPATH_WIDTH];
        sel_b    = b_in[i*DATAPATH_WIDTH +: DATAPATH_WIDTH];
        sel_ctrl = ctrl_in[i*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH];
      end
    end
  end

  assign rr_next  = (win_q == PTR_W'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
  assign busy_out = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_in) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack/done default low every cycle so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      win_q        <= '0;
      win_grant_q  <= '0;
      ack_out      <= '0;
      done_out     <= '0;
      result_out   <= '0;
      zero_out     <= 1'b0;
      alu_a_out    <= '0;
      alu_b_out    <= '0;
      alu_ctrl_out <= '0;
    end else begin
      ack_out  <= '0;
      done_out <= '0;
      case (state_q)
        IDLE: begin
          if (|req_in) begin
            alu_a_out    <= sel_a;
            alu_b_out    <= sel_b;
            alu_ctrl_out <= sel_ctrl;
            win_q        <= pick_idx;
            win_grant_q  <= pick_grant;
            ack_out      <= pick_grant;
          end
        end
        EXEC: begin
          result_out   <= alu_accum_in;
          zero_out     <= alu_zero_in;
          done_out     <= win_grant_q;
          rr_ptr       <= rr_next;
          alu_a_out    <= '0;
          alu_b_out    <= '0;
          alu_ctrl_out <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NC = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC-1:0]     req_in = '0;
  logic [NC*DW-1:0]  a_in, b_in;
  logic [NC*4-1:0]   ctrl_in;
  logic [NC-1:0]     ack_out, done_out;
  logic [DW-1:0]     result_out, alu_a_out, alu_b_out, alu_accum_in;
  logic              zero_out, busy_out, alu_zero_in;
  logic [3:0]        alu_ctrl_out;

  logic [DW-1:0] a_v [NC];
  logic [DW-1:0] b_v [NC];
  logic [3:0]    c_v [NC];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      a_in[i*DW +: DW] = a_v[i];
      b_in[i*DW +: DW] = b_v[i];
      ctrl_in[i*4 +: 4] = c_v[i];
    end
  end

  // Reference ALU standing in for the shared combinational instance.
  always_comb begin
    case (alu_ctrl_out)
      ALU_ADD: alu_accum_in = alu_a_out + alu_b_out;
      ALU_SUB: alu_accum_in = alu_a_out - alu_b_out;
      ALU_AND: alu_accum_in = alu_a_out & alu_b_out;
      ALU_OR:  alu_accum_in = alu_a_out | alu_b_out;
      ALU_NOT: alu_accum_in = ~alu_a_out;
      ALU_XOR: alu_accum_in = alu_a_out ^ alu_b_out;
      ALU_SLT: alu_accum_in = ($signed(alu_a_out) < $signed(alu_b_out)) ? 64'd1 : 64'd0;
      ALU_SLL: alu_accum_in = alu_a_out << alu_b_out[5:0];
      ALU_SRL: alu_accum_in = alu_a_out >> alu_b_out[5:0];
      default: alu_accum_in = '0;
    endcase
    alu_zero_in = (alu_accum_in == '0);
  end

  alu_share_arbiter #(.DATAPATH_WIDTH(DW), .NUM_CORES(NC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .ctrl_in      (ctrl_in),
    .ack_out      (ack_out),
    .done_out     (done_out),
    .result_out   (result_out),
    .zero_out     (zero_out),
    .busy_out     (busy_out),
    .alu_a_out    (alu_a_out),
    .alu_b_out    (alu_b_out),
    .alu_ctrl_out (alu_ctrl_out),
    .alu_accum_in (alu_accum_in),
    .alu_zero_in  (alu_zero_in)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int core, input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    a_v[core] = a;
    b_v[core] = b;
    c_v[core] = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) set_op(i, '0, '0, '0);
    do_reset();
    chk("rst_ack", ack_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_result", result_out, 0);
    chk("rst_zero", zero_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_alu_a", alu_a_out, 0);

    // Single ADD from core 1.
    set_op(1, 64'd5, 64'd3, ALU_ADD);
    req_in = 4'b0010;
    tick();
    chk("add_ack", ack_out, 4'b0010);
    chk("add_busy", busy_out, 1);
    chk("add_alu_a", alu_a_out, 5);
    chk("add_alu_ctrl", alu_ctrl_out, ALU_ADD);
    req_in = '0;
    tick();
    chk("add_done", done_out, 4'b0010);
    chk("add_ack_low", ack_out, 0);
    chk("add_result", result_out, 8);
    chk("add_zero", zero_out, 0);
    tick();
    chk("add_idle_done", done_out, 0);
    chk("add_idle_busy", busy_out, 0);
    chk("add_idle_alu_a", alu_a_out, 0);
    chk("add_hold_result", result_out, 8);

    // SUB of equal operands from core 0 (pointer at 2 wraps to 0).
    set_op(0, 64'h1234, 64'h1234, ALU_SUB);
    req_in = 4'b0001;
    tick();
    chk("sub_ack", ack_out, 4'b0001);
    req_in = '0;
    tick();
    chk("sub_done", done_out, 4'b0001);
    chk("sub_result", result_out, 0);
    chk("sub_zero", zero_out, 1);
    tick();

    // All four requesting from reset: grants 0,1,2,3,0, three cycles apart.
    do_reset();
    for (int i = 0; i < NC; i++) set_op(i, 64'(10*i + 1), 64'(i), ALU_ADD);
    req_in = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int core;
      core = g % NC;
      tick();
      chk($sformatf("rr%0d_ack", g), ack_out, 64'(1 << core));
      tick();
      chk($sformatf("rr%0d_done", g), done_out, 64'(1 << core));
      chk($sformatf("rr%0d_ack_gap", g), ack_out, 0);
      chk($sformatf("rr%0d_result", g), result_out, 64'(11*core + 1));
      tick();
      chk($sformatf("rr%0d_idle_ack", g), ack_out, 0);
      chk($sformatf("rr%0d_idle_busy", g), busy_out, 0);
    end
    req_in = '0;

    // Core 2 raises a request only during core 0's EXEC/DONE, then withdraws.
    set_op(0, 64'hff, 64'h0f, ALU_AND);
    set_op(2, 64'h1, 64'h1, ALU_ADD);
    req_in = 4'b0001;
    tick();
    chk("wd_ack0", ack_out, 4'b0001);
    req_in = 4'b0100;
    tick();
    chk("wd_done0", done_out, 4'b0001);
    chk("wd_result0", result_out, 64'h0f);
    req_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wd_no_ack%0d", i), ack_out, 0);
      chk($sformatf("wd_no_busy%0d", i), busy_out, 0);
    end

    // Reset during EXEC: op lost, pointer back to 0.
    set_op(1, 64'd100, 64'd1, ALU_SUB);
    req_in = 4'b0010;
    tick();
    chk("mr_ack", ack_out, 4'b0010);
    req_in = '0;
    rst_n = 1'b0;
    #1;
    chk("mr_ack_clr", ack_out, 0);
    chk("mr_busy", busy_out, 0);
    chk("mr_alu_a", alu_a_out, 0);
    chk("mr_result", result_out, 0);
    chk("mr_zero", zero_out, 0);
    tick();
    chk("mr_no_done", done_out, 0);
    rst_n = 1'b1;
    set_op(0, 64'd7, 64'd9, ALU_SLT);
    set_op(3, 64'hf0, 64'd4, ALU_SRL);
    req_in = 4'b1001;
    tick();
    chk("mr_ptr0_ack", ack_out, 4'b0001);
    req_in = '0;
    tick();
    chk("mr_slt_result", result_out, 1);
    tick();
    req_in = 4'b1000;
    tick();
    chk("mr_core3_ack", ack_out, 4'b1000);
    req_in = '0;
    tick();
    chk("mr_core3_done", done_out, 4'b1000);
    chk("mr_srl_result", result_out, 64'hf);
    tick();

    // Unsupported opcode still completes.
    set_op(2, 64'd1, 64'd1, 4'd12);
    req_in = 4'b0100;
    tick();
    chk("ill_ack", ack_out, 4'b0100);
    req_in = '0;
    tick();
    chk("ill_done", done_out, 4'b0100);
    chk("ill_result", result_out, 0);
    chk("ill_zero", zero_out, 1);
    tick();
    chk("ill_idle", busy_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and round-robin arbiter that time-shares the single 64-bit ALU among NUM_CORES requesting cores.
- Per core: captures the operands and opcode, drives the ALU input ports from registers, captures the ALU result and returns it to the winning core with a done pulse.
- Position: between the core execute stages and the shared ALU instance, which remains a separate combinational block.

## Interface
- DATAPATH_WIDTH, 64, operand/result width; must match the ALU.
- NUM_CORES, 4, number of requesters; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  NUM_CORES  per-core request level.
- a_in  input  NUM_CORES*DATAPATH_WIDTH  flattened operand A; core i occupies slice [i*DATAPATH_WIDTH +: DATAPATH_WIDTH].
- b_in  input  NUM_CORES*DATAPATH_WIDTH  flattened operand B, same slicing as a_in.
- ctrl_in  input  NUM_CORES*4  flattened ALU opcode; core i occupies slice [i*4 +: 4].
- ack_out  output  NUM_CORES  one-hot one-cycle grant pulse.
- done_out  output  NUM_CORES  one-hot one-cycle completion pulse.
- result_out  output  DATAPATH_WIDTH  last captured ALU result.
- zero_out  output  1  last captured ALU zero flag.
- busy_out  output  1  high whenever state != IDLE.
- alu_a_out, alu_b_out  output  DATAPATH_WIDTH  operands driven to the ALU.
- alu_ctrl_out  output  4  opcode driven to the ALU.
- alu_accum_in  input  DATAPATH_WIDTH  ALU result.
- alu_zero_in  input  1  ALU zero flag.

## Operation
- State machine: IDLE -> EXEC -> DONE -> IDLE. No other transitions except reset.
- IDLE:
  - If req_in is non-zero, pick winner w round-robin: first requester at or after rr_ptr, wrapping NUM_CORES-1 -> 0.
  - At the edge: load op_a/op_b/op_ctrl from slice w, set ack_out[w], go to EXEC.
  - If req_in == 0: stay in IDLE, outputs unchanged.
- EXEC:
  - alu_* outputs are driven from the operand registers.
  - At the edge: capture result_out <= alu_accum_in and zero_out <= alu_zero_in, set done_out[w], set rr_ptr <= (w+1) mod NUM_CORES, go to DONE.
- DONE:
  - Unconditionally return to IDLE at the next edge.
  - All operand registers clear to 0, which also drives alu_* to 0.
- Requester rules:
  - Hold operands stable while req_in is high and until ack_out is seen.
  - Deassert req_in in the cycle after ack_out, or keep it high to request again.
  - A request dropped before ack is a legal withdrawal and is never granted.
- req_in is ignored in EXEC and DONE. New arrivals wait for IDLE.
- Opcodes pass through unchecked. Opcode 0 and opcodes >9 produce whatever the ALU returns (0xdeafdeafdeafdeaf, or 0); the arbiter still completes normally with done.
- result_out and zero_out hold their values until the next EXEC capture.
- rr_ptr width is clog2(NUM_CORES). When NUM_CORES is not a power of two, wrap explicitly; do not rely on natural overflow.

## Timing
- All outputs are registered except busy_out, which decodes state.
- Reset values: state IDLE, rr_ptr 0, ack_out 0, done_out 0, result_out 0, zero_out 0, alu_a_out/alu_b_out/alu_ctrl_out 0, busy_out 0.
- Latency: request sampled at edge E0 -> ack_out high during E0..E1 -> done_out and result_out valid during E1..E2 -> IDLE after E2, where the next request is sampled.
- Throughput: one operation per 3 cycles; back-to-back grants are 3 cycles apart.
- ack_out and done_out are exactly one cycle wide and at most one bit is set at a time.
- The ALU has one full cycle (EXEC) of combinational settle time from register outputs.
- Reset asserted mid-operation: return to IDLE immediately (asynchronously). No done is issued, the pending op is lost, and rr_ptr returns to 0.
- Simultaneous requests: exactly one winner per IDLE cycle; the others keep waiting. No requester waits more than NUM_CORES grants.

## Structure
- Shared package alu_pkg holds:
  - ALU opcode constants: ALU_NOP=0, ADD=1, SUB=2, AND=3, OR=4, NOT=5, XOR=6, SLT=7, SLL=8, SRL=9.
  - State encoding: IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
  - Default DATAPATH_WIDTH.
- Sub-module rr_pick: combinational round-robin priority selector. Inputs are req vector and pointer; outputs are one-hot grant and encoded index.
- The ALU is instantiated at the level above and connected through the alu_* ports, not inside this block.

## Test plan
- Reset then single request: core 1 with a=5, b=3, ctrl=1 -> ack_out=0010 one cycle later, done_out=0010 the cycle after, result_out=8, zero_out=0.
- SUB with equal operands: core 0 with a=b=0x1234, ctrl=2 -> result_out=0, zero_out=1.
- All four requesting continuously from reset -> grant order 0,1,2,3,0, one grant every 3 cycles, no starvation.
- Withdrawal: core 2 requests only during EXEC of core 0 and drops before IDLE -> core 2 is never acked.
- Reset mid-EXEC: assert rst_n=0 during EXEC -> no done_out, all outputs 0; the next request from core 3 is granted from rr_ptr=0.
- Illegal opcode: ctrl=12 -> done is still issued, result_out=0, zero_out=1.
